right_shift_rot_32: RTL and testbench
=====================================

Name: right_shift_rot_32

Overview:
32-bit right barrel shifter/rotator with a registered output, used in the shifter/rotater block of the pipelined processor's execute datapath. Each cycle it shifts the data operand right by a 5-bit amount. Vacated MSBs are filled with zeros (logical shift) or with the bits shifted out of the LSB end (rotate). The result is captured in an output register on the rising clock edge.

Parameters:
none (data width fixed at 32, shift amount fixed at 5 bits)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
in  input  32  data operand
rotate  input  1  mode select: 1 = rotate right, 0 = logical shift right
select  input  5  shift/rotate amount, 0..31
out  output  32  registered result

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n = 0, out = 32'h0000_0000 immediately, without waiting for a clock edge. The first capture occurs on the first rising clk edge after rst_n returns to 1.
- Combinational core: five cascaded 2:1 mux stages, shifting by 1, 2, 4, 8 and 16 when select[0..4] respectively is 1.
  - Stage k input bit i takes bit i+2^k when i+2^k ≤ 31.
  - Otherwise it takes 0 (rotate = 0) or bit (i+2^k−32) (rotate = 1).
- Shift (rotate = 0): result = in >> select, zero-filled. No sign extension.
- Rotate (rotate = 1): result = (in >> select) | (in << (32 − select)), taken mod 2^32.
- select = 0: result = in in both modes (pass-through).
- select = 31, shift mode: result = {31'b0, in[31]}.
- select = 31, rotate mode: result = {in[30:0], in[31]}.
- Latency: exactly 1 cycle.
  - On each rising clk edge with rst_n = 1, out captures f(in, rotate, select) sampled at that edge.
  - out holds its value between edges.
  - Input changes between edges have no effect on out until the next edge.
- No enable or handshake: a new result is registered every cycle. Back-to-back operations are fully pipelined at 1 result per cycle.
- Reset asserted mid-operation: out clears at once. The pending result is discarded, not captured.
- No X-propagation: all 32 result bits are defined for every select value.

Test Plan:
1. Reset: rst_n = 0, in = 32'hFFFF_FFFF -> out = 32'h0; out stays 0 across clk edges while reset is held.
2. Shift: in = 32'hF000_0001, select = 4, rotate = 0 -> after 1st rising edge, out = 32'h0F00_0000.
3. Rotate: in = 32'hF000_0001, select = 4, rotate = 1 -> out = 32'h1F00_0000.
4. Boundaries:
   - select = 0 with in = 32'hA5A5_A5A5, either mode -> out = 32'hA5A5_A5A5.
   - in = 32'h8000_0001, select = 31, rotate = 0 -> out = 32'h0000_0001.
   - Same in and select, rotate = 1 -> out = 32'h0000_0003.
5. Latency/pipelining: change in/select/rotate every cycle (e.g. 32'h1234_5678 rot 8 -> 32'h7812_3456, then shift 16 -> 32'h0000_1234). Each result appears exactly one edge after its inputs are applied; mid-cycle input glitches are not reflected in out.
6. Asynchronous reset: assert rst_n low between clock edges while out ≠ 0 -> out = 0 before the next edge. Deassert -> the next edge captures the current result.

Source files
------------

// File: rtl/right_shift_rot_32.sv
`default_nettype none
// ============================================================================
//  Module      : right_shift_rot_32
//  Description : 32-bit right barrel shifter / rotator with a registered
//                result. Five cascaded 2:1 mux stages shift by 1, 2, 4, 8
//                and 16 under control of select[0..4]. Vacated MSBs are
//                zero-filled (logical shift) or refilled with the bits that
//                fall off the LSB end (rotate).
//  Revision    : 1.0 - initial release
// ============================================================================
module right_shift_rot_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in,
  input  logic        rotate,
  input  logic [4:0]  select,
  output logic [31:0] out
);

  localparam int c_WIDTH  = 32;
  localparam int c_STAGES = 5;

  // Stage k consumes w_stage[k] and produces w_stage[k+1].
  // w_stage[0] is the raw operand, and w_stage[c_STAGES] is the final result.
  logic [c_WIDTH-1:0] w_stage [0:c_STAGES];
  logic [c_WIDTH-1:0] r_out;

  assign w_stage[0] = in;

  genvar k;
  generate
    for (k = 0; k < c_STAGES; k++) begin : g_stage
      localparam int c_SH = 1 << k;

      logic [c_WIDTH-1:0] w_shifted;
      logic [c_WIDTH-1:0] w_wrap;
      logic [c_WIDTH-1:0] w_moved;

      // The bits that move down always come from i+2^k.
      assign w_shifted = w_stage[k] >> c_SH;

      // The top 2^k bits are refilled from the low end only when rotating.
      // Otherwise they stay zero, so no sign extension ever happens.
      assign w_wrap  = rotate ? (w_stage[k] << (c_WIDTH - c_SH)) : '0;
      assign w_moved = w_shifted | w_wrap;

      assign w_stage[k+1] = select[k] ? w_moved : w_stage[k];
    end
  endgenerate

  // Output register. Reset clears it asynchronously, so a result that is
  // pending when reset arrives is discarded rather than captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_stage[c_STAGES];
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_right_shift_rot_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_right_shift_rot_32
//  Description : Directed, self-checking bench for right_shift_rot_32.
//                Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_right_shift_rot_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] in;
  logic        rotate;
  logic [4:0]  select;
  logic [31:0] out;

  int vectors;
  int miscompares;

  right_shift_rot_32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .rotate (rotate),
    .select (select),
    .out    (out)
  );

  // 10 time-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] expected);
    vectors++;
    assert (out === expected)
    else begin
      miscompares++;
      $error("FAIL %s: out=%08h expected=%08h", tag, out, expected);
    end
  endtask

  // Drive the inputs on the falling edge, then wait until just after the
  // next rising edge so that the newly registered result can be sampled.
  task automatic apply(input logic [31:0] d, input logic rot, input logic [4:0] sel);
    @(negedge clk);
    in     = d;
    rotate = rot;
    select = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b1;
    in     = 32'hFFFF_FFFF;
    rotate = 1'b1;
    select = 5'd5;

    // Reset clears out without any clock edge, and holds it at zero
    #1 rst_n = 1'b0;
    #1 check("reset_async", 32'h0000_0000);
    @(posedge clk); #1 check("reset_hold_1", 32'h0000_0000);
    @(posedge clk); #1 check("reset_hold_2", 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function
    apply(32'hF000_0001, 1'b0, 5'd4);  check("shift4",        32'h0F00_0000);
    apply(32'hF000_0001, 1'b1, 5'd4);  check("rot4",          32'h1F00_0000);
    apply(32'hA5A5_A5A5, 1'b0, 5'd0);  check("sel0_shift",    32'hA5A5_A5A5);
    apply(32'hA5A5_A5A5, 1'b1, 5'd0);  check("sel0_rot",      32'hA5A5_A5A5);
    apply(32'h8000_0001, 1'b0, 5'd31); check("sel31_shift",   32'h0000_0001);
    apply(32'h8000_0001, 1'b1, 5'd31); check("sel31_rot",     32'h0000_0003);
    apply(32'hDEAD_BEEF, 1'b0, 5'd1);  check("shift1",        32'h6F56_DF77);
    apply(32'hDEAD_BEEF, 1'b1, 5'd1);  check("rot1",          32'hEF56_DF77);
    apply(32'h8000_0000, 1'b0, 5'd16); check("shift16_nosx",  32'h0000_8000);
    apply(32'h0000_FFFF, 1'b1, 5'd16); check("rot16",         32'hFFFF_0000);
    apply(32'h1234_5678, 1'b0, 5'd2);  check("shift2",        32'h048D_159E);

    // Back-to-back operations, one result per edge
    apply(32'h1234_5678, 1'b1, 5'd8);  check("pipe_rot8",     32'h7812_3456);
    // Glitch the inputs mid-cycle. out must hold its value.
    in = 32'hFFFF_FFFF; rotate = 1'b0; select = 5'd0;
    #2 check("glitch_hold", 32'h7812_3456);
    apply(32'h1234_5678, 1'b0, 5'd16); check("pipe_shift16",  32'h0000_1234);
    apply(32'h1234_5678, 1'b1, 5'd4);  check("pipe_rot4",     32'h8123_4567);

    // Reset asserted between edges while out is non-zero
    #2 rst_n = 1'b0;
    #1 check("midcycle_reset", 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_hold", 32'h0000_0000);
    @(posedge clk); #1 check("post_reset_capture", 32'h8123_4567);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
